// File: rtl/prog_mem_loader.sv
// Host byte-stream loader for program memory; holds the core in reset while loading.
// Define PROG_LOADER_CHECKSUM_EN to add the trailing 8-bit checksum byte and check.
module prog_mem_loader #(
  parameter int unsigned PC_WIDTH      = 9,
  parameter int unsigned INST_WIDTH    = 12,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  input  logic [7:0]            i_in_data,
  output logic                  o_in_ready,
  output logic                  o_mem_we,
  output logic [PC_WIDTH-1:0]   o_mem_addr,
  output logic [INST_WIDTH-1:0] o_mem_wdata,
  output logic                  o_core_hold,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR_H = 3'd1;
  localparam logic [2:0] ADDR_L = 3'd2;
  localparam logic [2:0] COUNT  = 3'd3;
  localparam logic [2:0] DATA_L = 3'd4;
  localparam logic [2:0] DATA_H = 3'd5;
  localparam logic [2:0] WRITE  = 3'd6;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM   = 3'd7;
`endif

  localparam logic [7:0] CMD_LOAD    = 8'hA5;
  localparam logic [7:0] CMD_RELEASE = 8'h5A;

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic [2:0]            w_after_last;
  logic [7:0]            r_addr_hi;
  logic [7:0]            r_data_lo;
  logic [PC_WIDTH-1:0]   r_next_addr;
  logic [PC_WIDTH-1:0]   r_mem_addr;
  logic [INST_WIDTH-1:0] r_mem_wdata;
  logic [8:0]            r_remain;
  logic                  r_core_hold;
  logic                  r_err;
  logic                  w_xfer;
  logic                  w_last;

  assign w_xfer = i_in_valid && o_in_ready;
  assign w_last = (r_remain == 9'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_csum_total;

  assign w_after_last = CSUM;
  // Kept 8 bits wide so the zero test is modulo 256.
  assign w_csum_total = r_sum + i_in_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum <= 8'd0;
    end else if (w_xfer) begin
      if (r_state == IDLE) begin
        r_sum <= 8'd0;
      end else if (r_state >= ADDR_H && r_state <= DATA_H) begin
        r_sum <= w_csum_total;
      end
    end
  end
`else
  assign w_after_last = IDLE;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (w_xfer && i_in_data == CMD_LOAD) w_state_next = ADDR_H;
      ADDR_H: if (w_xfer) w_state_next = ADDR_L;
      ADDR_L: if (w_xfer) w_state_next = COUNT;
      COUNT:  if (w_xfer) w_state_next = DATA_L;
      DATA_L: if (w_xfer) w_state_next = DATA_H;
      DATA_H: if (w_xfer) w_state_next = WRITE;
      WRITE:  w_state_next = w_last ? w_after_last : DATA_L;
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM:   if (w_xfer) w_state_next = IDLE;
`endif
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_addr_hi   <= 8'd0;
      r_data_lo   <= 8'd0;
      r_next_addr <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_remain    <= 9'd0;
      r_core_hold <= HOLD_AT_RESET;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        case (r_state)
          IDLE: begin
            if (i_in_data == CMD_LOAD) begin
              r_err       <= 1'b0;
              r_core_hold <= 1'b1;
            end else if (i_in_data == CMD_RELEASE) begin
              r_core_hold <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
          ADDR_H: r_addr_hi   <= i_in_data;
          ADDR_L: r_next_addr <= PC_WIDTH'({r_addr_hi, i_in_data});
          COUNT:  r_remain    <= (i_in_data == 8'd0) ? 9'd256 : {1'b0, i_in_data};
          DATA_L: r_data_lo   <= i_in_data;
          // Address/data registers change only here, so they hold between writes.
          DATA_H: begin
            r_mem_addr  <= r_next_addr;
            r_mem_wdata <= INST_WIDTH'({i_in_data, r_data_lo});
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          CSUM:   if (w_csum_total != 8'd0) r_err <= 1'b1;
`endif
          default: ;
        endcase
      end
      if (r_state == WRITE) begin
        r_next_addr <= r_next_addr + PC_WIDTH'(1);
        r_remain    <= r_remain - 9'd1;
      end
    end
  end

  assign o_in_ready  = (r_state != WRITE);
  assign o_mem_we    = (r_state == WRITE);
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_core_hold = r_core_hold;
  assign o_busy      = (r_state != IDLE);
  assign o_err       = r_err;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed steps plus randomized loads
// compared against an address/word list model of the expected writes.
module tb_prog_mem_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        o_in_ready;
  logic        o_mem_we;
  logic [8:0]  o_mem_addr;
  logic [11:0] o_mem_wdata;
  logic        o_core_hold;
  logic        o_busy;
  logic        o_err;

  int checks   = 0;
  int failures = 0;
  int gap_max  = 0;

  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] words[256];

  prog_mem_loader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (o_in_ready),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_core_hold (o_core_hold),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write strobe seen, packed as {7'b0, addr, 4'b0, data}.
  always @(negedge clk) begin
    if (o_mem_we === 1'b1) obs_q.push_back({7'd0, o_mem_addr, 4'd0, o_mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (o_in_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(n < 8), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pack_write(input int addr, input logic [15:0] w);
    return {16'((addr) % 512), 4'd0, w[11:0]};
  endfunction

  // Full LOAD of n words from words[]; queues the writes the spec implies.
  task automatic do_load(input logic [7:0] ahi, input logic [7:0] alo, input int n);
    int base;
    logic [7:0] sum;
    base = (int'(ahi) * 256 + int'(alo)) % 512;
    send_byte(8'hA5);
    send_byte(ahi);
    send_byte(alo);
    send_byte(8'(n));
    sum = ahi + alo + 8'(n);
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][7:0]);
      send_byte(words[i][15:8]);
      sum = sum + words[i][7:0] + words[i][15:8];
      exp_q.push_back(pack_write(base + i, words[i]));
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'd0 - sum);
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state, idle link.
    repeat (10) @(negedge clk);
    check("rst_core_hold", o_core_hold, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_err", o_err, 1'b0);
    check("rst_in_ready", o_in_ready, 1'b1);
    check("rst_mem_addr", o_mem_addr, 9'd0);
    check("rst_mem_wdata", o_mem_wdata, 12'd0);
    check("rst_no_writes", obs_q.size(), 0);

    // Directed two-word load.
    send_byte(8'hA5);
    check("load_busy", o_busy, 1'b1);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h02);
    send_byte(8'h23);
    send_byte(8'h01);
    check("wr_latency_we", o_mem_we, 1'b1);
    check("wr_in_ready_low", o_in_ready, 1'b0);
    send_byte(8'h45);
    send_byte(8'h0A);
    check("wr2_latency_we", o_mem_we, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h7B);
`endif
    repeat (3) @(negedge clk);
    exp_q.push_back({7'd0, 9'h010, 4'd0, 12'h123});
    exp_q.push_back({7'd0, 9'h011, 4'd0, 12'hA45});
    compare_writes("directed");
    check("dir_busy", o_busy, 1'b0);
    check("dir_core_hold", o_core_hold, 1'b1);
    check("dir_err", o_err, 1'b0);
    check("dir_addr_held", o_mem_addr, 9'h011);
    send_byte(8'h5A);
    check("release_hold", o_core_hold, 1'b0);

    // Address wrap, then a 256-word load with garbage upper address bits.
    gap_max = 1;
    for (int i = 0; i < 256; i++) words[i] = 16'($urandom);
    do_load(8'h01, 8'hFF, 2);
    check("wrap_addr0", 32'(obs_q.size() > 0 ? obs_q[0][24:16] : 9'h0AA), 32'h1FF);
    check("wrap_addr1", 32'(obs_q.size() > 1 ? obs_q[1][24:16] : 9'h0AA), 32'h000);
    compare_writes("wrap");
    do_load(8'($urandom), 8'($urandom), 256);
    compare_writes("count256");
    check("c256_busy", o_busy, 1'b0);

    // Bad command, then LOAD clears err; reset lands mid word 2 of a 4-word load.
    send_byte(8'h5A);
    send_byte(8'h77);
    check("badcmd_err", o_err, 1'b1);
    check("badcmd_busy", o_busy, 1'b0);
    check("badcmd_hold", o_core_hold, 1'b0);
    send_byte(8'hA5);
    check("load_clears_err", o_err, 1'b0);
    check("load_sets_hold", o_core_hold, 1'b1);
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h04);
    send_byte(8'hCD);
    send_byte(8'hAB);
    send_byte(8'h11);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_we", o_mem_we, 1'b0);
    check("midrst_hold", o_core_hold, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back({7'd0, 9'h020, 4'd0, 12'hBCD});
    compare_writes("midrst");

    // Randomized loads.
    gap_max = 2;
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) words[i] = 16'($urandom);
      do_load(8'($urandom), 8'($urandom), n);
      compare_writes("rand");
      check("rand_busy", o_busy, 1'b0);
      check("rand_err", o_err, 1'b0);
      check("rand_hold", o_core_hold, 1'b1);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    gap_max = 0;
    words[0] = 16'h0001;
    do_load(8'h00, 8'h00, 1);
    check("csum_good_err", o_err, 1'b0);
    compare_writes("csum_good");
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (2) @(negedge clk);
    check("csum_bad_err", o_err, 1'b1);
    check("csum_bad_busy", o_busy, 1'b0);
    check("csum_bad_hold", o_core_hold, 1'b1);
    exp_q.push_back({7'd0, 9'h000, 4'd0, 12'h001});
    compare_writes("csum_bad");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
